// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic register chain carrying one ARQ-bit payload word
// through STAGES stages. It sits between processor pipeline stages and adds a
// global stall (freeze) and flush (drop everything held) on top of the
// per-stage valid/ready flow.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both high in the cycle before that edge. A producer
// keeps valid high and its data stable until that edge. in_ready may depend
// combinationally on out_ready. in_valid never reaches out_valid in the same
// cycle. stall and flush force both in_ready and out_valid low, so no transfer
// completes on either side in those cycles.
module pipe_stage_chain #(
    parameter int ARQ    = 16,
    parameter int STAGES = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ARQ-1:0]                 in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ARQ-1:0]                 out_data,
    input  logic                           stall,
    input  logic                           flush,
    output logic [$clog2(STAGES+1)-1:0]    occ
);

    localparam int OCC_W = $clog2(STAGES + 1);

    // Stage 0 is the input side, stage STAGES-1 drives the output.
    logic [STAGES-1:0]           v;
    logic [STAGES-1:0][ARQ-1:0]  d;

    // r[i]: stage i may load this cycle. r[STAGES] is the downstream ready.
    logic [STAGES:0]             r;
    logic                        ready_acc;

    // Word presented to each stage from its upstream neighbour.
    logic [STAGES-1:0]           nxt_v;
    logic [STAGES-1:0][ARQ-1:0]  nxt_d;

    // Chain moves only when neither stall nor flush is asserted.
    logic                        advance;

    // Ready chain: a stage can load when it is empty or its successor loads.
    // Built through an accumulator so no bit of r depends on another bit of r.
    always_comb begin
        r         = '0;
        ready_acc = out_ready;
        r[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ready_acc = ready_acc | ~v[i];
            r[i]      = ready_acc;
        end
    end

    // Source of each stage: the upstream interface for stage 0, else stage i-1.
    always_comb begin
        nxt_v    = '0;
        nxt_d    = '0;
        nxt_v[0] = in_valid;
        nxt_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            nxt_v[i] = v[i-1];
            nxt_d[i] = d[i-1];
        end
    end

    // Interface outputs; both sides are closed during reset, stall and flush.
    always_comb begin
        advance   = ~stall & ~flush;
        in_ready  = rst & r[0] & advance;
        out_valid = rst & v[STAGES-1] & advance;
        out_data  = out_valid ? d[STAGES-1] : '0;
    end

    // Occupancy straight from the valid bits, deliberately not masked by
    // stall/flush so it shows what the chain is holding.
    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(v[i]);
        end
    end

    // Stage registers: reset clears everything, flush drops valids but leaves
    // data alone, stall freezes. Data loads only with a valid word so empty
    // slots do not churn the payload registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v <= '0;
            d <= '0;
        end else if (flush) begin
            v <= '0;
        end else if (!stall) begin
            for (int i = 0; i < STAGES; i++) begin
                if (r[i]) begin
                    v[i] <= nxt_v[i];
                    if (nxt_v[i]) begin
                        d[i] <= nxt_d[i];
                    end
                end
            end
        end
    end

endmodule
